// File: rtl/dsp_mac_sequencer_if.sv
// rtl/dsp_mac_sequencer_if.sv - sample stream in and dot-product result out of the MAC sequencer
interface dsp_mac_sequencer_if #(
    parameter int CW = 16
);
    logic                 s_valid;
    logic                 s_ready;
    logic signed [24:0]   s_a;
    logic signed [24:0]   s_d;
    logic signed [17:0]   s_b;
    logic                 s_sub;
    logic                 s_last;

    logic                 m_valid;
    logic signed [47:0]   m_data;
    logic [CW-1:0]        m_count;

    modport master (
        output s_valid, s_a, s_d, s_b, s_sub, s_last,
        input  s_ready,
        input  m_valid, m_data, m_count
    );

    modport slave (
        input  s_valid, s_a, s_d, s_b, s_sub, s_last,
        output s_ready,
        output m_valid, m_data, m_count
    );
endinterface

// File: rtl/dsp_mac_sequencer.sv
// rtl/dsp_mac_sequencer.sv - feeds a DSP48E1 p = b*(d+-a) + Z slice and captures one dot product per vector
module dsp_mac_sequencer #(
    parameter int CW = 16
) (
    input  logic               clock,
    input  logic               reset,
    dsp_mac_sequencer_if.slave sif,
    output logic signed [24:0] dsp_a,
    output logic signed [24:0] dsp_d,
    output logic signed [17:0] dsp_b,
    output logic [4:0]         dsp_mode,
    output logic               dsp_ce1,
    output logic               dsp_ce2,
    output logic               dsp_cem,
    output logic               dsp_cep,
    input  logic signed [47:0] dsp_p
);
    localparam logic [1:0]    Z_ZERO  = 2'b00;
    localparam logic [1:0]    Z_P     = 2'b10;
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic               accept;

    logic               first_q,  first_d;
    logic [CW-1:0]      cnt_q,    cnt_d;
    logic signed [24:0] a_q,      a_d;
    logic signed [24:0] d_q,      d_d;
    logic               sub_q,    sub_d;
    logic signed [17:0] b1_q,     b1_d;
    logic signed [17:0] b2_q,     b2_d;
    logic [1:0]         z1_q,     z1_d;
    logic [1:0]         z2_q,     z2_d;
    logic [1:0]         z3_q,     z3_d;
    logic [4:0]         last_q,   last_d;
    logic [CW-1:0]      cp_q [5];
    logic [CW-1:0]      cp_d [5];
    logic               m_valid_q, m_valid_d;
    logic signed [47:0] m_data_q,  m_data_d;
    logic [CW-1:0]      m_count_q, m_count_d;

    assign sif.s_ready = !reset;
    assign accept      = sif.s_valid & sif.s_ready;

    always_comb begin
        first_d = first_q;
        cnt_d   = cnt_q;
        if (accept) begin
            first_d = sif.s_last;
            if (first_q) begin
                cnt_d = CNT_ONE;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end

        // Bubbles zero the pre-adder inputs so the slice adds a zero product.
        a_d   = accept ? sif.s_a   : '0;
        d_d   = accept ? sif.s_d   : '0;
        sub_d = accept ? sif.s_sub : 1'b0;
        b1_d  = accept ? sif.s_b   : '0;
        b2_d  = b1_q;

        // Z select trails A/D so it reaches the OPMODE register with the product at M.
        z1_d  = (accept && first_q) ? Z_ZERO : Z_P;
        z2_d  = z1_q;
        z3_d  = z2_q;

        last_d = {last_q[3:0], accept & sif.s_last};
        cp_d[0] = cnt_d;
        for (int i = 1; i < 5; i++) begin
            cp_d[i] = cp_q[i-1];
        end

        m_valid_d = last_q[4];
        m_data_d  = last_q[4] ? dsp_p    : m_data_q;
        m_count_d = last_q[4] ? cp_q[4]  : m_count_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            first_q   <= 1'b1;
            cnt_q     <= '0;
            a_q       <= '0;
            d_q       <= '0;
            sub_q     <= 1'b0;
            b1_q      <= '0;
            b2_q      <= '0;
            z1_q      <= Z_ZERO;
            z2_q      <= Z_ZERO;
            z3_q      <= Z_ZERO;
            last_q    <= '0;
            for (int i = 0; i < 5; i++) begin
                cp_q[i] <= '0;
            end
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_count_q <= '0;
        end else begin
            first_q   <= first_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            d_q       <= d_d;
            sub_q     <= sub_d;
            b1_q      <= b1_d;
            b2_q      <= b2_d;
            z1_q      <= z1_d;
            z2_q      <= z2_d;
            z3_q      <= z3_d;
            last_q    <= last_d;
            for (int i = 0; i < 5; i++) begin
                cp_q[i] <= cp_d[i];
            end
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_count_q <= m_count_d;
        end
    end

    assign dsp_a    = a_q;
    assign dsp_d    = d_q;
    assign dsp_b    = b2_q;
    assign dsp_mode = {sub_q, z3_q, 2'b00};
    assign dsp_ce1  = 1'b1;
    assign dsp_ce2  = 1'b1;
    assign dsp_cem  = 1'b1;
    assign dsp_cep  = 1'b1;

    assign sif.m_valid = m_valid_q;
    assign sif.m_data  = m_data_q;
    assign sif.m_count = m_count_q;
endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// tb/tb_dsp_mac_sequencer.sv - directed bench for dsp_mac_sequencer driving a behavioural DSP48E1 slice
module tb_dsp_mac_sequencer;
    logic clk;
    logic reset;

    dsp_mac_sequencer_if #(.CW(16)) sif1 ();
    dsp_mac_sequencer_if #(.CW(2))  sif2 ();

    logic [1:0][24:0] dsp_a, dsp_d;
    logic [1:0][17:0] dsp_b;
    logic [1:0][4:0]  dsp_mode;
    logic [1:0]       ce1, ce2, cem, cep;
    logic [1:0][47:0] dsp_p;

    logic [1:0][24:0] a_r, d_r;
    logic [1:0]       sub_r;
    logic [1:0][25:0] ad_r;
    logic [1:0][17:0] b_r;
    logic [1:0][43:0] m_r;
    logic [1:0][4:0]  op_r;
    logic [1:0][47:0] p_r;

    typedef struct {
        longint data;
        longint data2;
        int     count;
        int     count2;
        bit     v1;
        bit     v2;
        int     cyc;
    } pulse_t;

    pulse_t pulses[$];
    int     acc_q[$];
    int     cyc = 0;
    int     n_checks = 0;
    int     n_errors = 0;

    dsp_mac_sequencer #(.CW(16)) dut1 (
        .clock(clk), .reset(reset), .sif(sif1),
        .dsp_a(dsp_a[0]), .dsp_d(dsp_d[0]), .dsp_b(dsp_b[0]), .dsp_mode(dsp_mode[0]),
        .dsp_ce1(ce1[0]), .dsp_ce2(ce2[0]), .dsp_cem(cem[0]), .dsp_cep(cep[0]),
        .dsp_p(dsp_p[0])
    );

    dsp_mac_sequencer #(.CW(2)) dut2 (
        .clock(clk), .reset(reset), .sif(sif2),
        .dsp_a(dsp_a[1]), .dsp_d(dsp_d[1]), .dsp_b(dsp_b[1]), .dsp_mode(dsp_mode[1]),
        .dsp_ce1(ce1[1]), .dsp_ce2(ce2[1]), .dsp_cem(cem[1]), .dsp_cep(cep[1]),
        .dsp_p(dsp_p[1])
    );

    assign sif2.s_valid = sif1.s_valid;
    assign sif2.s_a     = sif1.s_a;
    assign sif2.s_d     = sif1.s_d;
    assign sif2.s_b     = sif1.s_b;
    assign sif2.s_sub   = sif1.s_sub;
    assign sif2.s_last  = sif1.s_last;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Slice model: A/D/INMODE regs, AD reg, B reg, M reg, OPMODE reg, P reg.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            a_r[k]   <= dsp_a[k];
            d_r[k]   <= dsp_d[k];
            sub_r[k] <= dsp_mode[k][4];
            ad_r[k]  <= sub_r[k] ? ({d_r[k][24], d_r[k]} - {a_r[k][24], a_r[k]})
                                 : ({d_r[k][24], d_r[k]} + {a_r[k][24], a_r[k]});
            b_r[k]   <= dsp_b[k];
            m_r[k]   <= $signed(ad_r[k]) * $signed(b_r[k]);
            op_r[k]  <= dsp_mode[k];
            p_r[k]   <= (op_r[k][3:2] == 2'b10) ? p_r[k] + {{4{m_r[k][43]}}, m_r[k]}
                                                : {{4{m_r[k][43]}}, m_r[k]};
        end
    end
    assign dsp_p = p_r;

    always @(negedge clk) begin
        if (sif1.m_valid || sif2.m_valid) begin
            pulses.push_back('{data: sif1.m_data, data2: sif2.m_data,
                               count: int'(sif1.m_count), count2: int'(sif2.m_count),
                               v1: sif1.m_valid, v2: sif2.m_valid, cyc: cyc});
        end
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send(input logic signed [24:0] a, input logic signed [24:0] d,
                        input logic signed [17:0] b, input bit sub, input bit last);
        sif1.s_valid = 1'b1;
        sif1.s_a     = a;
        sif1.s_d     = d;
        sif1.s_b     = b;
        sif1.s_sub   = sub;
        sif1.s_last  = last;
        @(negedge clk);
        if (last) acc_q.push_back(cyc);
        sif1.s_valid = 1'b0;
        sif1.s_a     = '0;
        sif1.s_d     = '0;
        sif1.s_b     = '0;
        sif1.s_sub   = 1'b0;
        sif1.s_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_test();
        pulses.delete();
        acc_q.delete();
    endtask

    task automatic check_pulse(input string tag, input int i, input longint data,
                               input int count, input int count2);
        if (i < pulses.size() && i < acc_q.size()) begin
            check({tag, "_v1"},      pulses[i].v1, 1);
            check({tag, "_v2"},      pulses[i].v2, 1);
            check({tag, "_data"},    pulses[i].data, data);
            check({tag, "_data2"},   pulses[i].data2, data);
            check({tag, "_count"},   pulses[i].count, count);
            check({tag, "_count2"},  pulses[i].count2, count2);
            check({tag, "_latency"}, pulses[i].cyc - acc_q[i], 5);
        end
    endtask

    initial begin
        logic signed [24:0] big_ad;
        logic signed [17:0] big_b;
        longint             exp_big;

        reset        = 1'b1;
        sif1.s_valid = 1'b0;
        sif1.s_a     = '0;
        sif1.s_d     = '0;
        sif1.s_b     = '0;
        sif1.s_sub   = 1'b0;
        sif1.s_last  = 1'b0;
        idle(3);
        check("rst_s_ready",  sif1.s_ready, 0);
        check("rst_m_valid",  sif1.m_valid, 0);
        check("rst_m_data",   sif1.m_data, 0);
        check("rst_m_count",  sif1.m_count, 0);
        check("rst_dsp_mode", dsp_mode[0], 0);
        check("rst_dsp_a",    dsp_a[0], 0);
        check("rst_dsp_b",    dsp_b[0], 0);
        reset = 1'b0;
        idle(1);
        check("run_s_ready", sif1.s_ready, 1);
        check("ce_all",      {ce1[0], ce2[0], cem[0], cep[0]}, 4'hf);

        start_test();
        send(1, 2, 3, 0, 0);
        send(4, 0, -5, 0, 0);
        send(-1, 1, 7, 0, 1);
        idle(4);
        check("bubble_dsp_a", dsp_a[0], 0);
        check("bubble_dsp_d", dsp_d[0], 0);
        check("bubble_mode",  dsp_mode[0], 5'b01000);
        idle(6);
        check("t1_pulses", pulses.size(), 1);
        check_pulse("t1", 0, -11, 3, 3);
        check("hold_m_data",  sif1.m_data, -11);
        check("hold_m_count", sif1.m_count, 3);

        start_test();
        for (int r = 0; r < 3; r++) begin
            idle($urandom_range(0, 3));
            send(1, 2, 3, 0, 0);
            idle($urandom_range(0, 3));
            send(4, 0, -5, 0, 0);
            idle($urandom_range(0, 3));
            send(-1, 1, 7, 0, 1);
        end
        idle(10);
        check("t2_pulses", pulses.size(), 3);
        for (int i = 0; i < 3; i++) check_pulse($sformatf("t2_%0d", i), i, -11, 3, 3);

        start_test();
        send(10, 3, 2, 1, 1);
        idle(10);
        check("t3_pulses", pulses.size(), 1);
        check_pulse("t3", 0, -14, 1, 1);

        start_test();
        send(1, 1, 1, 0, 0);
        send(1, 1, 1, 0, 1);
        send(2, 0, 2, 0, 1);
        idle(10);
        check("t4_pulses", pulses.size(), 2);
        check_pulse("t4a", 0, 4, 2, 2);
        check_pulse("t4b", 1, 4, 1, 1);
        if (pulses.size() == 2) check("t4_gap", pulses[1].cyc - pulses[0].cyc, 1);

        start_test();
        big_ad  = 25'sh1000000;
        big_b   = 18'sh20000;
        exp_big = 64'sd1 <<< 44;
        for (int i = 0; i < 4; i++) send(big_ad, big_ad, big_b, 0, i == 3);
        for (int i = 0; i < 5; i++) send(1, 0, 1, 0, i == 4);
        idle(10);
        check("t5_pulses", pulses.size(), 2);
        check_pulse("t5_big", 0, exp_big, 4, 3);
        check_pulse("t5_sat", 1, 5, 5, 3);

        start_test();
        send(5, 5, 5, 0, 0);
        send(6, 6, 6, 0, 0);
        reset = 1'b1;
        idle(1);
        check("midrst_s_ready", sif1.s_ready, 0);
        reset = 1'b0;
        send(1, 0, 1, 0, 1);
        idle(10);
        check("t6_pulses", pulses.size(), 1);
        check_pulse("t6", 0, 1, 1, 1);
        check("t6_s_ready", sif1.s_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
